inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit: the initiator side of the instruction-memory read interface. It owns the program counter, drives the word address into `InstMem`, captures the returned 32-bit word with its PC into a 2-entry prefetch buffer, and hands entries to decode over a valid/ready handshake. It sits between `InstMem` and the decode stage and accepts branch redirects from execute.

## Interface
- `ADDR_W`, 6, word-address width; matches `InstMem` address port
- `DATA_W`, 32, instruction width
- `RESET_PC`, 0, word address fetched first after reset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_addr`  out  ADDR_W  word address to `InstMem`; combinational copy of PC register
- `imem_data`  in  DATA_W  `InstMem` read data; combinational in `imem_addr`, same cycle
- `br_valid`  in  1  redirect request
- `br_target`  in  ADDR_W  redirect word address
- `out_valid`  out  1  buffer head valid
- `out_ready`  in  1  decode accepts head
- `out_inst`  out  DATA_W  head instruction
- `out_pc`  out  ADDR_W  head word address
- `halted`  out  1  fetch stopped on SYSTEM opcode (see Configuration)

## Operation
- State: `pc` (ADDR_W), 2-entry FIFO of {pc, inst}, `count` (0..2), `halted`.
- Reset: `pc`=RESET_PC, `count`=0, `halted`=0; therefore `out_valid`=0, `imem_addr`=RESET_PC, `out_inst`/`out_pc` don't-care (implemented as 0).
- pop = `out_valid & out_ready`.
- fetch = `!halted & !br_valid & (count<2 | pop)`.
- On fetch: push {pc, imem_data}; `pc` <= pc+1, wrapping modulo 2^ADDR_W (63 -> 0 at default).
- Simultaneous push and pop with count=2 or 1: count unchanged, order preserved.
- Redirect (`br_valid`=1): FIFO flushed (count<=0), `pc`<=`br_target`, `halted`<=0, no push and no pop that cycle (`out_ready` ignored).
- Priority: `rst` > redirect > push/pop.
- Full (count=2, no pop): no fetch, `pc` holds, `imem_addr` stable.
- Empty: `out_valid`=0, `out_inst`/`out_pc` hold last values.
- Reset mid-operation: all buffered entries discarded, same as power-on reset.

## Timing
- `imem_addr` changes only on clock edges; the read is captured in the same cycle.
- Load-to-use latency: address presented in cycle N -> `out_valid` with that instruction in cycle N+1.
- After `rst` deasserts at edge E: cycle E fetches RESET_PC; `out_valid`=1 from E+1.
- Redirect sampled at edge R: fetch of `br_target` in cycle R+1 (edge R+1), `out_valid`=1 from R+2 with `out_pc`=`br_target`.
- Sustained throughput with `out_ready`=1 held: one instruction per cycle, consecutive PCs.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_inst`/`out_pc` remain stable.

## Configuration
- `FETCH_HALT_EN` defined: on push of an instruction with `inst[6:0]`=7'b1110011, `halted`<=1 on that edge and fetch stops. The SYSTEM instruction itself is buffered and delivered. Cleared only by `rst` or a redirect.
- Not defined: `halted` is tied to 0 and fetch is never blocked by the instruction content.

## Test plan
- Reset then `out_ready`=1, memory word k = 32'h1000_0000+k: `out_pc` = 0,1,2,… on consecutive cycles starting at cycle 1; `out_inst` matches.
- Hold `out_ready`=0 for 5 cycles after reset: `count` reaches 2, `imem_addr` stuck at 2, `out_pc`=0 stable; release -> pcs 0,1,2 delivered with no gaps or duplicates.
- `br_valid`=1, `br_target`=20 while the buffer holds pcs 3 and 4: both dropped, next delivered `out_pc`=20 two cycles later, then 21.
- Run from `br_target`=62: delivered pcs 62, 63, 0, 1 (wrap-around).
- `rst` asserted for one cycle while `count`=2: `out_valid`=0 next cycle, then `out_pc`=0 (RESET_PC).
- With `FETCH_HALT_EN`, word 2 = 32'h0000_0073: pcs 0,1,2 delivered, `halted`=1, `imem_addr` frozen at 3; redirect to 30 clears `halted` and delivers pc 30. Without the macro, pc 3 follows pc 2.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, InstMem address drive, 2-entry prefetch buffer to decode.
// Optional FETCH_HALT_EN: stop fetching after a SYSTEM opcode is buffered.
module inst_fetch #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  // Entry 0 is always the head; entry 1 only meaningful when count is 2.
  logic [ADDR_W-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [DATA_W-1:0] e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;
  logic              halted_q;
  logic              pop, fetch;

`ifdef FETCH_HALT_EN
  logic halted_d;
`else
  assign halted_q = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = e0_inst_q;
  assign out_pc    = e0_pc_q;
  assign halted    = halted_q;

  assign pop   = out_valid & out_ready & ~br_valid;
  assign fetch = ~halted_q & ~br_valid & ((count_q != 2'd2) | pop);

  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;
`ifdef FETCH_HALT_EN
    halted_d  = halted_q;
`endif
    if (br_valid) begin
      count_d  = 2'd0;
      pc_d     = br_target;
`ifdef FETCH_HALT_EN
      halted_d = 1'b0;
`endif
    end else begin
      if (fetch) pc_d = pc_q + 1'b1;
      unique case ({fetch, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            e1_pc_d   = pc_q;
            e1_inst_d = imem_data;
          end else begin
            e0_pc_d   = pc_q;
            e0_inst_d = imem_data;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_pc_d   = pc_q;
            e0_inst_d = imem_data;
          end else begin
            e1_pc_d   = pc_q;
            e1_inst_d = imem_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Draining the last entry leaves entry 0 in place so the outputs hold.
          if (count_q == 2'd2) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
          end
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
`ifdef FETCH_HALT_EN
      if (fetch && imem_data[6:0] == 7'b1110011) halted_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= ADDR_W'(RESET_PC);
      count_q   <= 2'd0;
      e0_pc_q   <= '0;
      e0_inst_q <= '0;
      e1_pc_q   <= '0;
      e1_inst_q <= '0;
`ifdef FETCH_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
`ifdef FETCH_HALT_EN
      halted_q  <= halted_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, all checked
// against a queue-based model of the fetch buffer.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, br_valid, out_ready, out_valid, halted;
  logic [5:0]  imem_addr, br_target, out_pc;
  logic [31:0] imem_data, out_inst;
  logic [31:0] mem [64];

  int compared = 0;
  int mismatched = 0;

  typedef struct { logic [5:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  logic [5:0]  m_pc;
  logic        m_halted;
  logic [5:0]  last_pc;
  logic [31:0] last_inst;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  inst_fetch #(.ADDR_W(6), .DATA_W(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .br_valid(br_valid), .br_target(br_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare current outputs with the model, then advance both across one edge.
  task automatic step();
    logic pop, fetch;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_pc",    32'(out_pc),    32'(q.size() > 0 ? q[0].pc : last_pc));
    chk("out_inst",  out_inst,       q.size() > 0 ? q[0].inst : last_inst);
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("halted",    32'(halted),    32'(m_halted));
    if (q.size() > 0) begin
      last_pc   = q[0].pc;
      last_inst = q[0].inst;
    end
    if (rst) begin
      q.delete(); m_pc = 6'd0; m_halted = 1'b0; last_pc = '0; last_inst = '0;
    end else if (br_valid) begin
      q.delete(); m_pc = br_target; m_halted = 1'b0;
    end else begin
      pop   = (q.size() > 0) && out_ready;
      fetch = !m_halted && (q.size() < 2 || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{pc: m_pc, inst: mem[m_pc]});
`ifdef FETCH_HALT_EN
        if (mem[m_pc][6:0] == 7'b1110011) m_halted = 1'b1;
`endif
        m_pc = m_pc + 6'd1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    rst = 1'b1; br_valid = 1'b0; br_target = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    q.delete(); m_pc = 6'd0; m_halted = 1'b0; last_pc = '0; last_inst = '0;
    step();                                   // reset state
    rst = 1'b0; out_ready = 1'b1; steps(8);   // streaming 0,1,2,...

    rst = 1'b1; step(); rst = 1'b0;           // stall with full buffer
    out_ready = 1'b0; steps(5);
    out_ready = 1'b1; steps(3);

    out_ready = 1'b0; steps(2);               // redirect discards buffered entries
    br_valid = 1'b1; br_target = 6'd20; step();
    br_valid = 1'b0; out_ready = 1'b1; steps(4);

    br_valid = 1'b1; br_target = 6'd62; step(); // wrap-around
    br_valid = 1'b0; steps(6);

    out_ready = 1'b0; steps(3);               // reset while full
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1; steps(4);

    mem[2] = 32'h0000_0073;                   // SYSTEM opcode at word 2
    rst = 1'b1; step(); rst = 1'b0;
    steps(8);
    br_valid = 1'b1; br_target = 6'd30; step();
    br_valid = 1'b0; steps(4);
    mem[2] = 32'h1000_0002;

    for (int k = 0; k < 64; k++)
      mem[k] = ($urandom_range(7) == 0) ? {$urandom, 7'b1110011} : 32'($urandom);
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(49) == 0);
      br_valid  = ($urandom_range(11) == 0);
      br_target = 6'($urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
